// File: rtl/fpu_wb_sched_if.sv
// Interface bundling the issue, writeback and hazard-query signals of fpu_wb_sched.
//   master : issue side / consumer (drives issue_*, flush, query_tag)
//   slave  : the scheduler itself (drives issue_ready, wb_*, slot_busy, inflight, query_busy)
interface fpu_wb_sched_if #(
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned LAT_W   = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned UNIT_W  = 4
);
  logic                 issue_valid;
  logic [LAT_W-1:0]     issue_lat;
  logic [TAG_W-1:0]     issue_tag;
  logic [UNIT_W-1:0]    issue_unit;
  logic                 issue_ready;
  logic                 flush;
  logic                 wb_valid;
  logic [TAG_W-1:0]     wb_tag;
  logic [UNIT_W-1:0]    wb_unit;
  logic [MAX_LAT-2:0]   slot_busy;
  logic [LAT_W-1:0]     inflight;
  logic [TAG_W-1:0]     query_tag;
  logic                 query_busy;

  modport master (
    output issue_valid, issue_lat, issue_tag, issue_unit, flush, query_tag,
    input  issue_ready, wb_valid, wb_tag, wb_unit, slot_busy, inflight, query_busy
  );

  modport slave (
    input  issue_valid, issue_lat, issue_tag, issue_unit, flush, query_tag,
    output issue_ready, wb_valid, wb_tag, wb_unit, slot_busy, inflight, query_busy
  );
endinterface

// File: rtl/fpu_wb_sched.sv
// Writeback scheduler for multi-cycle FPU units. Each accepted op reserves the single
// writeback slot of the cycle it completes in, using a shift-register reservation table
// T[1..MAX_LAT-1]; entry T[k] reaches the wb register after k edges.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fpu_wb_sched_if.slave (issue handshake, flush, writeback, occupancy, RAW query)
module fpu_wb_sched #(
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned LAT_W   = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned UNIT_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  fpu_wb_sched_if.slave  bus
);
  localparam int NE = int'(MAX_LAT) - 1;

  // Reservation table and writeback register
  logic [NE:1]        r_vld;
  logic [TAG_W-1:0]   r_tag  [NE:1];
  logic [UNIT_W-1:0]  r_unit [NE:1];
  logic               r_wb_valid;
  logic [TAG_W-1:0]   r_wb_tag;
  logic [UNIT_W-1:0]  r_wb_unit;
  logic [LAT_W-1:0]   r_inflight;

  logic [NE:1]        w_vld_nxt;
  logic [TAG_W-1:0]   w_tag_nxt  [NE:1];
  logic [UNIT_W-1:0]  w_unit_nxt [NE:1];
  logic               w_wb_valid_nxt;
  logic [TAG_W-1:0]   w_wb_tag_nxt;
  logic [UNIT_W-1:0]  w_wb_unit_nxt;
  logic [LAT_W-1:0]   w_inflight_nxt;

  logic               w_lat_ok;
  logic               w_slot_taken;
  logic               w_accept;
  logic               w_query_hit;

  // Issue admission: latency L lands in the cycle T[L] would write back, so T[L] must be
  // free. L == MAX_LAT has no matching entry and is always free.
  always_comb begin
    w_lat_ok     = (bus.issue_lat != '0) && (bus.issue_lat <= LAT_W'(MAX_LAT));
    w_slot_taken = 1'b0;
    for (int k = 1; k <= NE; k++) begin
      if (bus.issue_lat == LAT_W'(k) && r_vld[k]) w_slot_taken = 1'b1;
    end
  end

  assign bus.issue_ready = !bus.flush && w_lat_ok && !w_slot_taken;
  assign w_accept        = bus.issue_valid && bus.issue_ready;

  always_comb begin
    // Shift toward the wb register
    for (int k = 1; k < NE; k++) begin
      w_vld_nxt[k]  = r_vld[k+1];
      w_tag_nxt[k]  = r_tag[k+1];
      w_unit_nxt[k] = r_unit[k+1];
    end
    w_vld_nxt[NE]  = 1'b0;
    w_tag_nxt[NE]  = '0;
    w_unit_nxt[NE] = '0;

    w_wb_valid_nxt = r_vld[1];
    w_wb_tag_nxt   = r_tag[1];
    w_wb_unit_nxt  = r_unit[1];

    // The targeted entry is known empty, so the new op simply overrides the shift.
    if (w_accept) begin
      if (bus.issue_lat == LAT_W'(1)) begin
        w_wb_valid_nxt = 1'b1;
        w_wb_tag_nxt   = bus.issue_tag;
        w_wb_unit_nxt  = bus.issue_unit;
      end else begin
        for (int k = 1; k <= NE; k++) begin
          if (bus.issue_lat == LAT_W'(k + 1)) begin
            w_vld_nxt[k]  = 1'b1;
            w_tag_nxt[k]  = bus.issue_tag;
            w_unit_nxt[k] = bus.issue_unit;
          end
        end
      end
    end

    w_inflight_nxt = r_inflight + LAT_W'(w_accept) - LAT_W'(r_wb_valid);

    if (bus.flush) begin
      w_vld_nxt      = '0;
      w_wb_valid_nxt = 1'b0;
      w_wb_tag_nxt   = '0;
      w_wb_unit_nxt  = '0;
      w_inflight_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld      <= '0;
      r_tag      <= '{default: '0};
      r_unit     <= '{default: '0};
      r_wb_valid <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_unit  <= '0;
      r_inflight <= '0;
    end else begin
      r_vld      <= w_vld_nxt;
      r_tag      <= w_tag_nxt;
      r_unit     <= w_unit_nxt;
      r_wb_valid <= w_wb_valid_nxt;
      r_wb_tag   <= w_wb_tag_nxt;
      r_wb_unit  <= w_wb_unit_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  // RAW lookup covers T only; the wb register result is written this cycle.
  always_comb begin
    w_query_hit = 1'b0;
    for (int k = 1; k <= NE; k++) begin
      if (r_vld[k] && r_tag[k] == bus.query_tag) w_query_hit = 1'b1;
    end
  end

  assign bus.query_busy = (bus.query_tag != '0) && w_query_hit;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_tag     = r_wb_tag;
  assign bus.wb_unit    = r_wb_unit;
  assign bus.slot_busy  = r_vld;
  assign bus.inflight   = r_inflight;
endmodule

// File: tb/tb_fpu_wb_sched.sv
module tb_fpu_wb_sched;
  localparam int unsigned MAX_LAT = 8;
  localparam int unsigned LAT_W   = 4;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned UNIT_W  = 4;

  typedef struct {
    int                due;
    logic [TAG_W-1:0]  tag;
    logic [UNIT_W-1:0] unit;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  op_t  sb[$];

  always #5 clk = ~clk;

  fpu_wb_sched_if #(
    .MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .TAG_W(TAG_W), .UNIT_W(UNIT_W)
  ) bus_if ();

  fpu_wb_sched #(
    .MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .TAG_W(TAG_W), .UNIT_W(UNIT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, check against the scoreboard,
  // record an acceptance, then advance through the next rising edge.
  task automatic step(input logic v, input logic [LAT_W-1:0] lat, input logic [TAG_W-1:0] tg,
                      input logic [UNIT_W-1:0] un, input logic fl, input logic [TAG_W-1:0] qt);
    logic [MAX_LAT-2:0] exp_slots;
    int                 exp_inf;
    logic               exp_qb;
    logic               exp_rdy;
    int                 hit;
    bus_if.issue_valid = v;
    bus_if.issue_lat   = lat;
    bus_if.issue_tag   = tg;
    bus_if.issue_unit  = un;
    bus_if.flush       = fl;
    bus_if.query_tag   = qt;
    #1;
    exp_slots = '0;
    exp_inf   = 0;
    exp_qb    = 1'b0;
    hit       = -1;
    foreach (sb[i]) begin
      if (sb[i].due == cyc) hit = i;
      if (sb[i].due >= cyc) exp_inf++;
      if (sb[i].due > cyc && sb[i].due < cyc + int'(MAX_LAT)) begin
        exp_slots[sb[i].due - cyc - 1] = 1'b1;
        if (qt != '0 && sb[i].tag == qt) exp_qb = 1'b1;
      end
    end
    exp_rdy = !fl && lat >= 1 && lat <= LAT_W'(MAX_LAT);
    if (exp_rdy && lat != LAT_W'(MAX_LAT)) exp_rdy = !exp_slots[int'(lat) - 1];

    check("wb_valid", 32'(bus_if.wb_valid), 32'(hit >= 0));
    if (hit >= 0) begin
      check("wb_tag", 32'(bus_if.wb_tag), 32'(sb[hit].tag));
      check("wb_unit", 32'(bus_if.wb_unit), 32'(sb[hit].unit));
      sb.delete(hit);
    end
    check("slot_busy", 32'(bus_if.slot_busy), 32'(exp_slots));
    check("inflight", 32'(bus_if.inflight), 32'(exp_inf));
    check("issue_ready", 32'(bus_if.issue_ready), 32'(exp_rdy));
    check("query_busy", 32'(bus_if.query_busy), 32'(exp_qb));

    if (v && exp_rdy) sb.push_back('{due: cyc + int'(lat), tag: tg, unit: un});
    @(posedge clk);
    cyc++;
    if (fl) sb.delete();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [TAG_W-1:0] qt);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, qt);
  endtask

  initial begin
    rst                = 1'b1;
    bus_if.issue_valid = 1'b0;
    bus_if.issue_lat   = '0;
    bus_if.issue_tag   = '0;
    bus_if.issue_unit  = '0;
    bus_if.flush       = 1'b0;
    bus_if.query_tag   = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and single op with RAW query
    idle(1, 6'd5);
    step(1'b1, 4'd4, 6'd5, 4'd3, 1'b0, 6'd5);
    idle(6, 6'd5);

    // Conflict: lat=2 collides with lat=3 issued a cycle earlier, then retried
    step(1'b1, 4'd3, 6'd7, 4'd1, 1'b0, 6'd7);
    step(1'b1, 4'd2, 6'd8, 4'd2, 1'b0, 6'd8);
    step(1'b1, 4'd2, 6'd8, 4'd2, 1'b0, 6'd8);
    idle(4, 6'd8);

    // Back-to-back lat=1
    for (int i = 0; i < 10; i++) step(1'b1, 4'd1, 6'(10 + i), 4'(i), 1'b0, 6'(10 + i));
    idle(2, '0);

    // Illegal latencies
    step(1'b1, 4'd0, 6'd11, 4'd1, 1'b0, '0);
    step(1'b1, 4'd9, 6'd12, 4'd1, 1'b0, '0);
    idle(1, '0);

    // Mixed latencies sharing consecutive writeback slots
    step(1'b1, 4'd8, 6'd20, 4'd4, 1'b0, 6'd20);
    idle(5, 6'd20);
    step(1'b1, 4'd1, 6'd21, 4'd5, 1'b0, 6'd20);
    idle(3, 6'd21);

    // Flush with 4 ops in flight; a fresh issue in the flush cycle must be refused
    for (int i = 0; i < 4; i++) step(1'b1, 4'd8, 6'(30 + i), 4'(i), 1'b0, 6'd30);
    idle(1, 6'd31);
    step(1'b1, 4'd3, 6'd34, 4'd6, 1'b1, 6'd31);
    idle(10, 6'd31);

    // Duplicate tags stay busy until the last copy leaves the table
    step(1'b1, 4'd3, 6'd40, 4'd1, 1'b0, 6'd40);
    step(1'b1, 4'd5, 6'd40, 4'd2, 1'b0, 6'd40);
    idle(7, 6'd40);

    // Asynchronous reset mid-cycle with 3 ops in flight
    for (int i = 0; i < 3; i++) step(1'b1, 4'(6 + i), 6'(50 + i), 4'(i), 1'b0, '0);
    bus_if.issue_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_wb_valid", 32'(bus_if.wb_valid), 32'd0);
    check("rst_slot_busy", 32'(bus_if.slot_busy), 32'd0);
    check("rst_inflight", 32'(bus_if.inflight), 32'd0);
    sb.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    idle(10, 6'd51);
    step(1'b1, 4'd2, 6'd60, 4'd7, 1'b0, 6'd60);
    idle(3, 6'd60);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 6'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 19) == 0),
           6'($urandom_range(0, 7)));
    end
    idle(10, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
